multicycle_controller: RTL



---
 rtl/mips_ctrl_pkg.sv | 56 +++++
 rtl/mips_decode.sv | 80 ++++++++
 rtl/multicycle_controller.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, functs,
// ALU operation codes, memory access widths, FSM states and decode classes.
package mips_ctrl_pkg;

  // Primary opcodes (Instruction[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_MUL   = 6'b011100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // Function codes (Instruction[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_MUL = 6'b000010;

  // ALU operation codes
  localparam logic [4:0] ALU_ADD  = 5'b00001;
  localparam logic [4:0] ALU_SUB  = 5'b00010;
  localparam logic [4:0] ALU_MULT = 5'b00011;
  localparam logic [4:0] ALU_OR   = 5'b00111;
  localparam logic [4:0] ALU_SLT  = 5'b01110;

  // MemRead / MemWrite access width encodings
  localparam logic [1:0] MEM_NONE = 2'b00;
  localparam logic [1:0] MEM_WORD = 2'b01;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  typedef enum logic [3:0] {
    C_RTYPE,
    C_IMM,
    C_LOAD,
    C_STORE,
    C_BRANCH,
    C_JUMP,
    C_JAL,
    C_JR,
    C_MUL,
    C_ILLEGAL
  } iclass_t;

endpackage

// File: rtl/mips_decode.sv
// Combinational instruction decoder: classifies the IR contents and
// produces the ALU code and the static datapath selects for the FSM.
module mips_decode
  import mips_ctrl_pkg::*;
#(
  parameter int                    ALU_CTRL_W = 5,
  parameter logic [ALU_CTRL_W-1:0] ALU_NOP    = '1
) (
  input  logic [31:0]           instruction,
  output iclass_t               iclass,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic                  alu_src,
  output logic                  reg_dst,
  output logic                  mem_to_reg
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_fields;

  assign opcode = instruction[31:26];
  assign funct  = instruction[5:0];
  // Register and immediate fields are consumed by the datapath, not here.
  assign unused_fields = ^instruction[25:6];

  // Classify by opcode/funct; anything not listed is flagged illegal.
  always_comb begin
    iclass     = C_ILLEGAL;
    alu_ctrl   = ALU_NOP;
    alu_src    = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD: begin
            iclass = C_RTYPE; alu_ctrl = ALU_CTRL_W'(ALU_ADD);
            reg_dst = 1'b1; mem_to_reg = 1'b1;
          end
          FN_SUB: begin
            iclass = C_RTYPE; alu_ctrl = ALU_CTRL_W'(ALU_SUB);
            reg_dst = 1'b1; mem_to_reg = 1'b1;
          end
          FN_SLT: begin
            iclass = C_RTYPE; alu_ctrl = ALU_CTRL_W'(ALU_SLT);
            reg_dst = 1'b1; mem_to_reg = 1'b1;
          end
          FN_JR:   iclass = C_JR;
          default: iclass = C_ILLEGAL;
        endcase
      end
      OP_MUL: begin
        // mul writes rd like an R-type, so it selects rd as destination.
        if (funct == FN_MUL) begin
          iclass = C_MUL; alu_ctrl = ALU_CTRL_W'(ALU_MULT);
          reg_dst = 1'b1; mem_to_reg = 1'b1;
        end
      end
      OP_ADDI: begin
        iclass = C_IMM; alu_ctrl = ALU_CTRL_W'(ALU_ADD);
        alu_src = 1'b1; mem_to_reg = 1'b1;
      end
      OP_ORI: begin
        iclass = C_IMM; alu_ctrl = ALU_CTRL_W'(ALU_OR);
        alu_src = 1'b1; mem_to_reg = 1'b1;
      end
      OP_LW: begin
        iclass = C_LOAD; alu_ctrl = ALU_CTRL_W'(ALU_ADD); alu_src = 1'b1;
      end
      OP_SW: begin
        iclass = C_STORE; alu_ctrl = ALU_CTRL_W'(ALU_ADD); alu_src = 1'b1;
      end
      OP_BEQ, OP_BNE: iclass = C_BRANCH;
      OP_J:           iclass = C_JUMP;
      OP_JAL:         iclass = C_JAL;
      default:        iclass = C_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS controller: sequences each instruction through
// FETCH/DECODE/EXEC/MEM/WB with memory ready handshakes and a mul stall.
module multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter int                    ALU_CTRL_W = 5,
  parameter int                    MUL_CYCLES = 4,  // legal range 1..16
  parameter logic [ALU_CTRL_W-1:0] ALU_NOP    = ALU_CTRL_W'(5'b11111)
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [31:0]           Instruction,
  input  logic                  BranchOutput,
  input  logic                  MemReady,
  output logic                  InstrRead,
  output logic                  IRWrite,
  output logic                  PCWrite,
  output logic                  RegWrite,
  output logic                  ALUSrc,
  output logic                  RegDst,
  output logic                  MemToReg,
  output logic                  Jump,
  output logic                  Jr,
  output logic                  Jal,
  output logic                  PCSrc,
  output logic [1:0]            MemRead,
  output logic [1:0]            MemWrite,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic                  Illegal,
  output logic                  Busy
);

  // Last EXEC cycle index of a mul (counter runs 0..MUL_CYCLES-1).
  localparam logic [3:0] MUL_LAST = 4'(MUL_CYCLES - 1);

  state_t                state_reg, state_next;
  logic [3:0]            mul_cnt_reg, mul_cnt_next;

  iclass_t               dec_class;
  logic [ALU_CTRL_W-1:0] dec_alu;
  logic                  dec_alu_src;
  logic                  dec_reg_dst;
  logic                  dec_mem_to_reg;

  mips_decode #(
    .ALU_CTRL_W (ALU_CTRL_W),
    .ALU_NOP    (ALU_NOP)
  ) u_decode (
    .instruction (Instruction),
    .iclass      (dec_class),
    .alu_ctrl    (dec_alu),
    .alu_src     (dec_alu_src),
    .reg_dst     (dec_reg_dst),
    .mem_to_reg  (dec_mem_to_reg)
  );

  // State register and mul stall counter; reset abandons any instruction.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg   <= S_FETCH;
      mul_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      mul_cnt_reg <= mul_cnt_next;
    end
  end

  // Next-state and output decode; Reset overrides every output last.
  always_comb begin
    state_next   = state_reg;
    mul_cnt_next = '0;
    InstrRead    = 1'b0;
    IRWrite      = 1'b0;
    PCWrite      = 1'b0;
    RegWrite     = 1'b0;
    ALUSrc       = 1'b0;
    RegDst       = 1'b0;
    MemToReg     = 1'b0;
    Jump         = 1'b0;
    Jr           = 1'b0;
    Jal          = 1'b0;
    PCSrc        = 1'b0;
    MemRead      = MEM_NONE;
    MemWrite     = MEM_NONE;
    ALUControl   = ALU_NOP;
    Illegal      = 1'b0;
    Busy         = 1'b1;

    case (state_reg)
      S_FETCH: begin
        Busy      = 1'b0;
        InstrRead = 1'b1;
        if (MemReady) begin
          IRWrite    = 1'b1;
          PCWrite    = 1'b1;
          state_next = S_DECODE;
        end
      end

      S_DECODE: begin
        case (dec_class)
          C_JUMP: begin
            Jump = 1'b1; PCWrite = 1'b1; state_next = S_FETCH;
          end
          C_JAL: begin
            Jump = 1'b1; Jal = 1'b1; RegWrite = 1'b1; PCWrite = 1'b1;
            state_next = S_FETCH;
          end
          C_JR: begin
            Jr = 1'b1; PCWrite = 1'b1; state_next = S_FETCH;
          end
          C_ILLEGAL: begin
            Illegal = 1'b1; state_next = S_FETCH;
          end
          default: state_next = S_EXEC;
        endcase
      end

      S_EXEC: begin
        ALUControl = dec_alu;
        ALUSrc     = dec_alu_src;
        RegDst     = dec_reg_dst;
        case (dec_class)
          C_BRANCH: begin
            PCSrc      = BranchOutput;
            PCWrite    = BranchOutput;
            state_next = S_FETCH;
          end
          C_LOAD, C_STORE: state_next = S_MEM;
          C_MUL: begin
            if (mul_cnt_reg == MUL_LAST) begin
              state_next = S_WB;
            end else begin
              mul_cnt_next = mul_cnt_reg + 4'd1;
            end
          end
          default: state_next = S_WB;
        endcase
      end

      S_MEM: begin
        ALUSrc = dec_alu_src;
        RegDst = dec_reg_dst;
        if (dec_class == C_LOAD) begin
          MemRead = MEM_WORD;
        end else begin
          MemWrite = MEM_WORD;
        end
        if (MemReady) begin
          state_next = (dec_class == C_LOAD) ? S_WB : S_FETCH;
        end
      end

      S_WB: begin
        ALUSrc     = dec_alu_src;
        RegDst     = dec_reg_dst;
        MemToReg   = dec_mem_to_reg;
        RegWrite   = 1'b1;
        state_next = S_FETCH;
      end

      default: state_next = S_FETCH;
    endcase

    if (Reset) begin
      InstrRead  = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      RegWrite   = 1'b0;
      ALUSrc     = 1'b0;
      RegDst     = 1'b0;
      MemToReg   = 1'b0;
      Jump       = 1'b0;
      Jr         = 1'b0;
      Jal        = 1'b0;
      PCSrc      = 1'b0;
      MemRead    = MEM_NONE;
      MemWrite   = MEM_NONE;
      ALUControl = ALU_NOP;
      Illegal    = 1'b0;
      Busy       = 1'b0;
    end
  end

endmodule
